// File: rtl/bfp_block_align.sv
// Block-floating-point aligner: captures a 64-element block, finds its shared exponent,
// then streams each mantissa arithmetically right-shifted to that common exponent.

module find_max_exp #(
  parameter int expWidth = 4,
  parameter int N        = 64
) (
  input  logic [N*expWidth-1:0] i_exp,
  output logic [expWidth-1:0]   o_max
);

  always_comb begin
    o_max = '0;
    for (int i = 0; i < N; i++) begin
      if (i_exp[expWidth*i +: expWidth] > o_max) o_max = i_exp[expWidth*i +: expWidth];
    end
  end

endmodule

module bfp_block_align #(
  parameter int expWidth  = 4,
  parameter int mantWidth = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [64*expWidth-1:0]    in_exp,
  input  logic [64*mantWidth-1:0]   in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [mantWidth-1:0]      out_mant,
  output logic [expWidth-1:0]       out_exp,
  output logic [5:0]                out_idx,
  output logic                      out_last
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MAX    = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [expWidth-1:0]   r_exp_buf  [64];
  logic [mantWidth-1:0]  r_mant_buf [64];
  logic [64*expWidth-1:0] w_exp_flat;
  logic [expWidth-1:0]   r_shared_exp, w_max_exp, w_sel_shexp, w_sel_exp, w_shift;
  logic [5:0]            r_idx, w_sel_idx;
  logic [mantWidth-1:0]  r_out_mant, w_sel_mant, w_aligned;
  logic                  r_out_last;

  always_comb begin
    w_exp_flat = '0;
    for (int i = 0; i < 64; i++) w_exp_flat[expWidth*i +: expWidth] = r_exp_buf[i];
  end

  find_max_exp #(.expWidth(expWidth), .N(64)) u_find_max_exp (
    .i_exp (w_exp_flat),
    .o_max (w_max_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = S_MAX;
      S_MAX:    w_state_nxt = S_STREAM;
      S_STREAM: if (out_ready && r_idx == 6'd63) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // In MAX the first beat is prepared from the freshly computed maximum; in STREAM the next one.
  always_comb begin
    w_sel_idx   = (r_state == S_MAX) ? 6'd0 : r_idx + 6'd1;
    w_sel_shexp = (r_state == S_MAX) ? w_max_exp : r_shared_exp;
    w_sel_exp   = r_exp_buf[w_sel_idx];
    w_sel_mant  = r_mant_buf[w_sel_idx];
    w_shift     = w_sel_shexp - w_sel_exp;
    if (int'(w_shift) >= mantWidth) w_aligned = {mantWidth{w_sel_mant[mantWidth-1]}};
    else                            w_aligned = $signed(w_sel_mant) >>> w_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) begin
        r_exp_buf[i]  <= '0;
        r_mant_buf[i] <= '0;
      end
      r_shared_exp <= '0;
      r_idx        <= '0;
      r_out_mant   <= '0;
      r_out_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 64; i++) begin
              r_exp_buf[i]  <= in_exp[expWidth*i +: expWidth];
              r_mant_buf[i] <= in_mant[mantWidth*i +: mantWidth];
            end
          end
        end
        S_MAX: begin
          r_shared_exp <= w_max_exp;
          r_idx        <= 6'd0;
          r_out_mant   <= w_aligned;
          r_out_last   <= 1'b0;
        end
        S_STREAM: begin
          if (out_ready && r_idx != 6'd63) begin
            r_idx      <= w_sel_idx;
            r_out_mant <= w_aligned;
            r_out_last <= (w_sel_idx == 6'd63);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_STREAM);
  assign out_mant  = r_out_mant;
  assign out_exp   = r_shared_exp;
  assign out_idx   = r_idx;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_bfp_block_align.sv
// Directed bench for bfp_block_align: a per-cycle reference model plus literal timing/value checks.

module tb_bfp_block_align;

  localparam int EW = 4;
  localparam int MW = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [64*EW-1:0]  in_exp;
  logic [64*MW-1:0]  in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [MW-1:0]     out_mant;
  logic [EW-1:0]     out_exp;
  logic [5:0]        out_idx;
  logic              out_last;

  bfp_block_align #(.expWidth(EW), .mantWidth(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_exp    (in_exp),
    .in_mant   (in_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int t_exp [64];
  int t_mant[64];

  // Reference model state: 0 waiting for a block, 1 computing max, 2 streaming.
  int m_state = 0;
  int m_idx   = 0;
  int m_acc   = 0;
  int m_shexp = 0;
  int m_exp [64];
  int m_mant[64];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Floor division by 2^d, with sign fill once the shift covers the whole mantissa.
  function automatic int model_align(input int shexp, input int e, input int m);
    int d;
    int p;
    d = shexp - e;
    if (d >= MW) return (m < 0) ? -1 : 0;
    p = 1 << d;
    if (m >= 0) return m / p;
    return -((-m + p - 1) / p);
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_out_mant",  int'(out_mant), 0);
        chk("rst_out_exp",   int'(out_exp), 0);
        chk("rst_out_idx",   int'(out_idx), 0);
        chk("rst_out_last",  int'(out_last), 0);
        m_state = 0;
      end else begin
        chk("in_ready",  int'(in_ready),  (m_state == 0) ? 1 : 0);
        chk("out_valid", int'(out_valid), (m_state == 2) ? 1 : 0);
        if (m_state == 2) begin
          chk("out_idx",  int'(out_idx), m_idx);
          chk("out_exp",  int'(out_exp), m_shexp);
          chk("out_last", int'(out_last), (m_idx == 63) ? 1 : 0);
          chk("out_mant", int'($signed(out_mant)),
              model_align(m_shexp, m_exp[m_idx], m_mant[m_idx]));
        end
        if (m_state == 0) begin
          if (in_valid) begin
            m_shexp = 0;
            for (int i = 0; i < 64; i++) begin
              m_exp[i]  = int'(in_exp[EW*i +: EW]);
              m_mant[i] = int'($signed(in_mant[MW*i +: MW]));
              if (m_exp[i] > m_shexp) m_shexp = m_exp[i];
            end
            m_acc++;
            m_state = 1;
          end
        end else if (m_state == 1) begin
          m_state = 2;
          m_idx   = 0;
        end else if (out_ready) begin
          if (m_idx == 63) m_state = 0;
          else             m_idx++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < 64; i++) begin
      in_exp[EW*i +: EW]  = t_exp[i][EW-1:0];
      in_mant[MW*i +: MW] = t_mant[i][MW-1:0];
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected event", name);
  endtask

  task automatic send(input bit keep_valid);
    int n0;
    int n;
    n0 = m_acc;
    n  = 0;
    pack();
    in_valid = 1'b1;
    while (m_acc == n0 && n < 300) begin
      tick();
      n++;
    end
    if (m_acc == n0) timeout("send_accept");
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_beat(input int k);
    int n;
    n = 0;
    while (!(out_valid && out_idx == 6'(k)) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) timeout("wait_beat");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && !out_valid) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) timeout("wait_idle");
  endtask

  initial begin
    int n0;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_exp    = '0;
    in_mant   = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_rst_in_ready", int'(in_ready), 1);

    // All exponents equal: accept at edge E0, beats 0..63 after edges E1..E64, idle after E65.
    for (int i = 0; i < 64; i++) begin
      t_exp[i]  = 5;
      t_mant[i] = i - 32;
    end
    pack();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_e0_in_ready",  int'(in_ready), 0);
    chk("t1_e0_out_valid", int'(out_valid), 0);
    tick();
    chk("t1_e1_out_valid", int'(out_valid), 1);
    chk("t1_e1_out_idx",   int'(out_idx), 0);
    chk("t1_e1_out_mant",  int'(out_mant), 8'hE0);
    chk("t1_e1_out_exp",   int'(out_exp), 5);
    repeat (63) tick();
    chk("t1_e64_out_last", int'(out_last), 1);
    chk("t1_e64_out_idx",  int'(out_idx), 63);
    chk("t1_e64_out_mant", int'(out_mant), 8'h1F);
    tick();
    chk("t1_e65_in_ready",  int'(in_ready), 1);
    chk("t1_e65_out_valid", int'(out_valid), 0);

    // Single larger exponent.
    for (int i = 0; i < 64; i++) begin
      t_exp[i]  = (i == 17) ? 9 : 6;
      t_mant[i] = 'h40;
    end
    send(1'b0);
    wait_beat(17);
    chk("t2_elem17_mant", int'(out_mant), 8'h40);
    chk("t2_out_exp",     int'(out_exp), 9);
    wait_beat(18);
    chk("t2_elem18_mant", int'(out_mant), 8'h08);
    wait_idle();

    // Negative and overflowing shifts.
    for (int i = 0; i < 64; i++) begin
      t_exp[i]  = 15;
      t_mant[i] = 'h10;
    end
    t_mant[0] = 'h55;
    t_exp[1] = 0;  t_mant[1] = -3;
    t_exp[2] = 0;  t_mant[2] = 'h7F;
    t_exp[3] = 12; t_mant[3] = -128;
    send(1'b0);
    wait_beat(0);
    chk("t3_elem0_mant", int'(out_mant), 8'h55);
    wait_beat(1);
    chk("t3_elem1_mant", int'(out_mant), 8'hFF);
    wait_beat(2);
    chk("t3_elem2_mant", int'(out_mant), 8'h00);
    wait_beat(3);
    chk("t3_elem3_mant", int'(out_mant), 8'hF0);
    wait_idle();

    // Backpressure with in_valid held and input data churning every cycle.
    for (int i = 0; i < 64; i++) begin
      t_exp[i]  = int'($urandom_range(0, 15));
      t_mant[i] = int'($urandom_range(0, 255)) - 128;
    end
    n0 = m_acc;
    send(1'b1);
    n = 0;
    while (m_acc < n0 + 2 && n < 2000) begin
      for (int i = 0; i < 64; i++) begin
        t_exp[i]  = int'($urandom_range(0, 15));
        t_mant[i] = int'($urandom_range(0, 255)) - 128;
      end
      pack();
      out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (m_acc < n0 + 2) timeout("t4_second_block");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 64; i++) begin
      t_exp[i]  = i % 16;
      t_mant[i] = 100 - 3 * i;
    end
    send(1'b0);
    wait_beat(20);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", int'(out_valid), 0);
    chk("t5_rst_out_mant",  int'(out_mant), 0);
    chk("t5_rst_out_idx",   int'(out_idx), 0);
    chk("t5_rst_out_exp",   int'(out_exp), 0);
    chk("t5_rst_out_last",  int'(out_last), 0);
    chk("t5_rst_in_ready",  int'(in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t5_rel_in_ready",  int'(in_ready), 1);
    chk("t5_rel_out_valid", int'(out_valid), 0);
    for (int i = 0; i < 64; i++) begin
      t_exp[i]  = 5;
      t_mant[i] = i - 32;
    end
    send(1'b0);
    tick();
    chk("t5_fresh_out_valid", int'(out_valid), 1);
    chk("t5_fresh_out_idx",   int'(out_idx), 0);
    wait_idle();

    // Back-to-back blocks: second accepted at edge E66, its first beat after E67.
    for (int i = 0; i < 64; i++) begin
      t_exp[i]  = i % 8;
      t_mant[i] = i;
    end
    pack();
    in_valid = 1'b1;
    tick();
    chk("t6_e0_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 64; i++) begin
      t_exp[i]  = i % 13;
      t_mant[i] = -i;
    end
    pack();
    repeat (64) tick();
    chk("t6_e64_out_last", int'(out_last), 1);
    chk("t6_e64_out_exp",  int'(out_exp), 7);
    tick();
    chk("t6_e65_in_ready", int'(in_ready), 1);
    tick();
    chk("t6_e66_in_ready",  int'(in_ready), 0);
    chk("t6_e66_out_valid", int'(out_valid), 0);
    in_valid = 1'b0;
    tick();
    chk("t6_e67_out_valid", int'(out_valid), 1);
    chk("t6_e67_out_idx",   int'(out_idx), 0);
    chk("t6_e67_out_exp",   int'(out_exp), 12);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bfp_block_align.md
# bfp_block_align

Block-floating-point aligner placed directly downstream of `find_max_exp`. It captures one 64-element block of (exponent, mantissa) pairs in a single parallel beat and derives the block's shared exponent with an internal `find_max_exp` instance. It then streams the 64 mantissas out one per cycle, each arithmetically right-shifted by `(shared_exp - own_exp)`, so the next FFT stage sees a common exponent.

## Interface
- `expWidth`, default 4: exponent width, unsigned, identical to `find_max_exp`.
- `mantWidth`, default 8: mantissa width, signed two's complement.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: input block present.
- `in_ready`, output, 1: block can be accepted.
- `in_exp`, input, 64*expWidth: exponent of element i at `[expWidth*(i+1)-1 : expWidth*i]`.
- `in_mant`, input, 64*mantWidth: mantissa of element i at `[mantWidth*(i+1)-1 : mantWidth*i]`.
- `out_valid`, output, 1: output beat present.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_mant`, output, mantWidth: aligned mantissa.
- `out_exp`, output, expWidth: shared (maximum) exponent of the current block.
- `out_idx`, output, 6: element index 0..63.
- `out_last`, output, 1: high on the beat with `out_idx` = 63.

## Operation
- **Reset values:** state IDLE; `in_ready` = 1; `out_valid` = 0; `out_mant` = 0; `out_exp` = 0; `out_idx` = 0; `out_last` = 0. Both buffers are cleared to 0.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid & in_ready`, register `in_exp` and `in_mant` into the block buffers, then go to MAX.
- **MAX (exactly one cycle):**
  - `in_ready` = 0.
  - Register the `find_max_exp` output of the buffered exponents into `shared_exp`.
  - Clear `idx` to 0, then go to STREAM.
- **STREAM:**
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_exp` = `shared_exp`.
  - `out_idx` = `idx`.
  - `out_mant` = element[`idx`] mantissa shifted arithmetically right by d = `shared_exp - exp[idx]`.
  - On `out_valid & out_ready`:
    - If `idx` = 63, go to IDLE.
    - Otherwise increment `idx`.
  - When `out_ready` = 0, every output holds stable.
- **Shift rules:**
  - d is unsigned, 0..2^expWidth-1, and is never negative by construction.
  - If d ≥ mantWidth, the result is sign fill: 0 for a non-negative mantissa, all-ones (-1) for a negative one.
  - Truncation only, i.e. round toward -inf. No rounding and no saturation.
- **Output register:** `out_mant` / `out_idx` / `out_last` come from a registered output stage. They update only on entry to STREAM and on an accepted beat.
- **Buffer protection:** the buffers are written only in IDLE on an accepted input beat. They are never overwritten while a block is streaming.
- **Reset mid-block:** the block is dropped, all outputs return to their reset values, and no partial stream resumes after `rst_n` deasserts.
- **in_valid during MAX/STREAM:** ignored (`in_ready` = 0). The upstream source holds its data.

## Timing
- Input accepted at edge T → MAX during cycle T+1 → first beat (`idx` 0) has `out_valid` = 1 from edge T+2.
- With `out_ready` held at 1, beats `idx` 0..63 occupy cycles T+2..T+65. `out_last` is high in cycle T+65.
- `in_ready` returns to 1 in cycle T+66, so a new block can be accepted at edge T+66.
- Minimum block period: 66 cycles.
- Backpressure stretches STREAM one cycle per stalled beat. Latency to the first beat is unaffected.
- `in_ready` and `out_valid` are pure functions of state. There is no combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.
- The comparator tree (`find_max_exp`) sits between registers only, from the exponent buffer to `shared_exp`.

## Test plan
- **All exponents equal:** all exponents = 5, mantissas = i-32 (i = element index) → `out_exp` = 5 and each `out_mant` = i-32 unshifted; first beat at T+2, `out_last` at T+65, `in_ready` high at T+66.
- **Single larger exponent:** element 17 exp = 9, others exp = 6, mantissas 0x40 → `out_exp` = 9; element 17 gives 0x40, all others give 0x08.
- **Negative and overflow shifts:** element 0 exp = 15, element 1 exp = 0 with mantissa -3 (0xFD), element 2 exp = 0 with mantissa 0x7F → element 1 gives 0xFF (-1), element 2 gives 0x00 (d = 15 ≥ 8); element 3 exp = 12 with mantissa 0x80 gives 0xF0.
- **Backpressure:** toggle `out_ready` pseudo-randomly at 50% → all 64 beats delivered in order, no duplicates, outputs stable while stalled. Drive `in_valid` with new data throughout → the streamed data is unchanged and the second block is accepted only after `out_last` is accepted.
- **Reset mid-stream:** pulse `rst_n` low asynchronously at beat `idx` = 20 → `out_valid` drops immediately and all outputs read their reset values. After release, `in_ready` = 1 and a fresh block streams from `idx` 0.
- **Back-to-back blocks:** two blocks with `out_ready` = 1 → the second block is accepted exactly at T+66 and its first beat appears at T+68 with the second block's own `out_exp`.
